// File: rtl/tvip_reset_sequencer.sv
// tvip_reset_sequencer
// Produces a set of staged active-low resets. Every stage is held in reset for a
// programmable number of cycles, then the stages release one at a time in index
// order, with a programmable gap between releases. The power-on sequence uses the
// parameter defaults. A software start replays the sequence with sampled values.
module tvip_reset_sequencer #(
    parameter int NUM_STAGES            = 3,
    parameter int COUNT_WIDTH           = 8,
    parameter int DEFAULT_ASSERT_CYCLES = 4,
    parameter int DEFAULT_GAP_CYCLES    = 2,
    localparam int STAGE_WIDTH          = $clog2(NUM_STAGES + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_start,
    input  logic [COUNT_WIDTH-1:0] i_assert_cycles,
    input  logic [COUNT_WIDTH-1:0] i_gap_cycles,
    output logic [NUM_STAGES-1:0]  o_reset_n,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [STAGE_WIDTH-1:0] o_stage
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_RELEASE
    } state_t;

    // An assert length of 0 behaves like 1, so the power-on load is clamped here.
    localparam int DEF_ASSERT = (DEFAULT_ASSERT_CYCLES < 1) ? 1 : DEFAULT_ASSERT_CYCLES;

    localparam logic [COUNT_WIDTH-1:0] DEF_CNT    = COUNT_WIDTH'(DEF_ASSERT - 1);
    localparam logic [COUNT_WIDTH-1:0] DEF_GAP    = COUNT_WIDTH'(DEFAULT_GAP_CYCLES);
    localparam logic [STAGE_WIDTH-1:0] LAST_STAGE = STAGE_WIDTH'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0]  STAGE_LSB  = NUM_STAGES'(1);

    state_t                 state;
    logic [COUNT_WIDTH-1:0] cnt;
    logic [COUNT_WIDTH-1:0] gap;
    logic [STAGE_WIDTH-1:0] stage;

    // Shifting a 1 in from bit 0 releases the next stage. Because of this, the
    // release pattern stays monotonic by index.
    logic [NUM_STAGES-1:0] release_next;
    assign release_next = (o_reset_n << 1) | STAGE_LSB;

    // Sequencer FSM. All outputs are registered in this single block.
    // NOTE: all state uses non-blocking assignments. Each branch then sees the
    // pre-edge values of cnt/stage/o_reset_n, no matter how the statements are ordered.
    always_ff @(posedge clk) begin
        o_done <= 1'b0;
        // NOTE: the reset is synchronous, so it lives inside the clocked branch and
        // is left out of the sensitivity list.
        if (!reset_n) begin
            state     <= ST_ASSERT;
            cnt       <= DEF_CNT;
            gap       <= DEF_GAP;
            stage     <= '0;
            o_reset_n <= '0;
            o_busy    <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state     <= ST_ASSERT;
                        cnt       <= (i_assert_cycles == '0) ? '0 : i_assert_cycles - 1'b1;
                        gap       <= i_gap_cycles;
                        stage     <= '0;
                        o_reset_n <= '0;
                        o_busy    <= 1'b1;
                    end
                end

                ST_ASSERT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        o_reset_n <= release_next;
                        stage     <= stage + 1'b1;
                        cnt       <= gap;
                        if (NUM_STAGES == 1) begin
                            state  <= ST_IDLE;
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                        end else begin
                            state <= ST_RELEASE;
                        end
                    end
                end

                ST_RELEASE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        o_reset_n <= release_next;
                        stage     <= stage + 1'b1;
                        cnt       <= gap;
                        if (stage == LAST_STAGE) begin
                            state  <= ST_IDLE;
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    // stage is already a register, so o_stage is a direct alias of it.
    assign o_stage = stage;

endmodule

// File: tb/tb_tvip_reset_sequencer.sv
// tb_tvip_reset_sequencer
// Directed test of the staged reset sequencer. A cycle-level model derives every
// output from the sequence start edge S, the assert length and the gap. The model
// uses closed-form timing: stage k releases at edge S+max(A,1)+k*(G+1).
module tb_tvip_reset_sequencer;

    localparam int N  = 3;
    localparam int CW = 8;
    localparam int SW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_start;
    logic [CW-1:0] i_assert_cycles;
    logic [CW-1:0] i_gap_cycles;
    logic [N-1:0]  o_reset_n;
    logic          o_busy;
    logic          o_done;
    logic [SW-1:0] o_stage;

    tvip_reset_sequencer #(
        .NUM_STAGES(N),
        .COUNT_WIDTH(CW),
        .DEFAULT_ASSERT_CYCLES(4),
        .DEFAULT_GAP_CYCLES(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .i_start(i_start),
        .i_assert_cycles(i_assert_cycles),
        .i_gap_cycles(i_gap_cycles),
        .o_reset_n(o_reset_n),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_stage(o_stage)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint cyc     = 0;  // index of the most recent rising edge
    longint m_start = 0;  // S
    longint m_len   = 1;  // max(A,1)
    longint m_gap   = 0;  // G
    bit     m_busy  = 1'b1;
    bit     valid   = 1'b0;
    logic [N-1:0]  exp_rst;
    logic          exp_busy;
    logic          exp_done;
    longint        exp_stage;

    initial begin
        forever begin
            longint rel;
            @(posedge clk);
            cyc++;
            if (!reset_n) begin
                m_start = cyc;
                m_len   = 4;
                m_gap   = 2;
            end else if (!m_busy && i_start) begin
                m_start = cyc;
                m_len   = (i_assert_cycles == 0) ? 1 : longint'(i_assert_cycles);
                m_gap   = longint'(i_gap_cycles);
            end
            if (cyc < m_start + m_len) rel = 0;
            else rel = (cyc - m_start - m_len) / (m_gap + 1) + 1;
            if (rel > N) rel = N;
            exp_rst = '0;
            for (int k = 0; k < N; k++) if (k < rel) exp_rst[k] = 1'b1;
            exp_stage = rel;
            exp_busy  = (rel < N);
            exp_done  = (rel == N) && (cyc == m_start + m_len + (N - 1) * (m_gap + 1));
            m_busy    = exp_busy;
            valid     = 1'b1;
        end
    end

    // ---------------- per-cycle compare and event capture ----------------
    longint       rise_edge [N];
    longint       done_edge = -1;
    logic [N-1:0] prev_rst  = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (valid) begin
                check("o_reset_n", longint'(o_reset_n), longint'(exp_rst));
                check("o_busy",    longint'(o_busy),    longint'(exp_busy));
                check("o_done",    longint'(o_done),    longint'(exp_done));
                check("o_stage",   longint'(o_stage),   exp_stage);
                for (int k = 0; k < N; k++)
                    if (o_reset_n[k] && !prev_rst[k]) rise_edge[k] = cyc;
                if (o_done) done_edge = cyc;
                prev_rst = o_reset_n;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (!o_busy) begin
                idle = 1'b1;
                break;
            end
        end
        check("idle_timeout", longint'(idle), 1);
        @(negedge clk);
    endtask

    task automatic start_seq(input int a, input int g, output longint s);
        @(negedge clk);
        i_start         = 1'b1;
        i_assert_cycles = CW'(a);
        i_gap_cycles    = CW'(g);
        @(negedge clk);
        i_start = 1'b0;
        s = cyc;
    endtask

    task automatic check_releases(input string tag, input longint base,
                                  input longint r0, input longint r1, input longint r2);
        check({tag, "_rise0"}, rise_edge[0] - base, r0);
        check({tag, "_rise1"}, rise_edge[1] - base, r1);
        check({tag, "_rise2"}, rise_edge[2] - base, r2);
        check({tag, "_done"},  done_edge - base,    r2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        longint s;
        longint l;
        reset_n         = 1'b0;
        i_start         = 1'b0;
        i_assert_cycles = '0;
        i_gap_cycles    = '0;

        // Power-on: three edges in reset, then the defaults A=4 and G=2 apply.
        repeat (3) @(negedge clk);
        check("rst_reset_n", longint'(o_reset_n), 0);
        check("rst_busy",    longint'(o_busy),    1);
        check("rst_done",    longint'(o_done),    0);
        check("rst_stage",   longint'(o_stage),   0);
        reset_n = 1'b1;
        l = cyc;
        wait_idle();
        check_releases("por", l, 4, 7, 10);

        // A=1, G=0: the stages release on consecutive edges.
        start_seq(1, 0, s);
        check("a1_all_low", longint'(o_reset_n), 0);
        wait_idle();
        check_releases("a1g0", s, 1, 2, 3);

        // A=0 must behave exactly like A=1.
        start_seq(0, 0, s);
        wait_idle();
        check_releases("a0g0", s, 1, 2, 3);

        // A=3, G=1: starts at S+2 and S+5 are ignored. The A change at S+1 has no effect.
        start_seq(3, 1, s);
        i_assert_cycles = 8'd50;
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (2) @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_idle();
        check_releases("busy_ign", s, 3, 5, 7);

        // Reset mid-sequence at S+4 of an A=6 sequence. The power-on timing then applies.
        start_seq(6, 2, s);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_low",  longint'(o_reset_n), 0);
        check("mid_rst_busy", longint'(o_busy),    1);
        reset_n = 1'b1;
        l = cyc;
        wait_idle();
        check_releases("mid_por", l, 4, 7, 10);

        // i_start held high: a new sequence is accepted in each o_done cycle.
        @(negedge clk);
        i_start         = 1'b1;
        i_assert_cycles = 8'd2;
        i_gap_cycles    = 8'd1;
        @(negedge clk);
        s = cyc;
        repeat (7) @(negedge clk);
        check("b2b_first_done", done_edge - s, 6);
        check("b2b_relow",      longint'(o_reset_n), 0);
        check("b2b_rebusy",     longint'(o_busy),    1);
        repeat (6) @(negedge clk);
        i_start = 1'b0;
        wait_idle();
        check_releases("b2b_second", s, 9, 11, 13);

        // Maximum gap, G=255: the counter must not wrap.
        start_seq(1, 255, s);
        wait_idle();
        check_releases("gapmax", s, 1, 257, 513);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
